// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   ID-stage decode control unit. Instructions arrive on a valid/ready
//   handshake, are decoded into a control word and queued in a small FIFO
//   that feeds the ID/EX register. The unit also sequences processor halt
//   (run -> halt-pending -> halted) and squashes queued work on flush.
//
// Optional feature macro: DECODE_CTRL_EXC_EN
//   defined   : opcode 00010 (SIIC) sets out_exc, 00011 (RTI) sets out_rti.
//   undefined : both opcodes decode as no-ops; out_exc/out_rti tied to 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   instruction handshake, in_instr is the word
//   flush               synchronous squash of every queued entry
//   out_valid/out_ready control-word handshake toward ID/EX
//   out_*               decoded fields of the FIFO head (0 when empty)
//   halted              processor halted, sticky until reset
//
// State  | meaning
// RUN    | accepting instructions
// HLTPND | halt queued, waiting for it to leave the FIFO; input closed
// HALTED | halt entry consumed; input closed until reset
module decode_ctrl_pipe #(
  parameter int INSTR_W   = 16,
  parameter int ALUOP_W   = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_dest_sel,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic               out_alu_src,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_to_reg,
  output logic               out_mem_write,
  output logic               out_branch,
  output logic               out_jump,
  output logic               out_link,
  output logic               out_rt_rd,
  output logic               out_halt,
  output logic               out_exc,
  output logic               out_rti,
  output logic               halted
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {RUN = 2'd0, HALT_PEND = 2'd1, HALTED = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]         dest_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_write;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               branch;
    logic               jump;
    logic               link;
    logic               rt_rd;
    logic               halt;
`ifdef DECODE_CTRL_EXC_EN
    logic               exc;
    logic               rti;
`endif
  } ctrl_t;

  state_t             state_q, state_d;
  ctrl_t              mem_q [BUF_DEPTH];
  ctrl_t              mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  ctrl_t              dec, head;
  logic [4:0]         opcode;
  logic               push, pop;
  logic               unused_instr_bits;

  assign opcode = in_instr[INSTR_W-1 -: 5];
  // Only the opcode and the R-format function bits matter to decode.
  assign unused_instr_bits = ^in_instr;

  always_comb begin
    dec = '0;
    dec.alu_op[4:0] = opcode;
    if (ALUOP_W == 7 && (opcode == 5'b11011 || opcode == 5'b11010))
      dec.alu_op[ALUOP_W-1 -: 2] = in_instr[1:0];
    case (opcode)
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        dec.reg_write = 1'b1; dec.dest_sel = 2'b01;
      end
      5'b11011, 5'b11010, 5'b11100, 5'b11101, 5'b11110, 5'b11111: begin
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.dest_sel = 2'b00;
      end
      5'b11001: begin
        dec.reg_write = 1'b1; dec.dest_sel = 2'b00;
      end
      5'b10001: begin
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.dest_sel = 2'b01;
      end
      5'b10000: begin
        dec.mem_write = 1'b1; dec.rt_rd = 1'b1;
      end
      5'b10011: begin
        dec.mem_write = 1'b1; dec.rt_rd = 1'b1; dec.reg_write = 1'b1; dec.dest_sel = 2'b10;
      end
      5'b11000, 5'b10010: begin
        dec.reg_write = 1'b1; dec.dest_sel = 2'b10;
      end
      5'b01100, 5'b01101, 5'b01110, 5'b01111: dec.branch = 1'b1;
      5'b00100, 5'b00101: dec.jump = 1'b1;
      5'b00110, 5'b00111: begin
        dec.jump = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1; dec.dest_sel = 2'b11;
      end
      5'b00000: dec.halt = 1'b1;
`ifdef DECODE_CTRL_EXC_EN
      5'b00010: dec.exc = 1'b1;
      5'b00011: dec.rti = 1'b1;
`endif
      default: ;
    endcase
  end

  assign out_valid = (count_q != '0);
  assign in_ready  = (state_q == RUN) && (count_q < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign halted    = (state_q == HALTED);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Squash wins over any same-cycle push or pop.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)
        count_d = count_q + CNT_W'(1);
      else if (pop && !push)
        count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (push && dec.halt && !flush) state_d = HALT_PEND;
      HALT_PEND: begin
        if (flush)                state_d = RUN;
        else if (pop && head.halt) state_d = HALTED;
      end
      HALTED:    state_d = HALTED;
      default:   state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign out_dest_sel   = head.dest_sel;
  assign out_alu_op     = head.alu_op;
  assign out_alu_src    = head.alu_src;
  assign out_reg_write  = head.reg_write;
  assign out_mem_read   = head.mem_read;
  assign out_mem_to_reg = head.mem_to_reg;
  assign out_mem_write  = head.mem_write;
  assign out_branch     = head.branch;
  assign out_jump       = head.jump;
  assign out_link       = head.link;
  assign out_rt_rd      = head.rt_rd;
  assign out_halt       = head.halt;
`ifdef DECODE_CTRL_EXC_EN
  assign out_exc        = head.exc;
  assign out_rti        = head.rti;
`else
  assign out_exc        = 1'b0;
  assign out_rti        = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_dest_sel;
  logic [6:0]  out_alu_op;
  logic        out_alu_src, out_reg_write, out_mem_read, out_mem_to_reg, out_mem_write;
  logic        out_branch, out_jump, out_link, out_rt_rd, out_halt, out_exc, out_rti;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.INSTR_W(16), .ALUOP_W(7), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_dest_sel(out_dest_sel),
    .out_alu_op(out_alu_op), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_link(out_link), .out_rt_rd(out_rt_rd),
    .out_halt(out_halt), .out_exc(out_exc), .out_rti(out_rti), .halted(halted)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b want 0", halted); end
    n_cmp++; if ({out_dest_sel, out_alu_op, out_reg_write, out_halt, out_jump} !== 12'h000) begin
      n_err++; $display("FAIL rst_out_fields got %h want 000", {out_dest_sel, out_alu_op, out_reg_write, out_halt, out_jump});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_addi();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'h4125; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", out_valid); end
    n_cmp++; if (out_reg_write !== 1'b1) begin n_err++; $display("FAIL addi_reg_write got %b want 1", out_reg_write); end
    n_cmp++; if (out_dest_sel !== 2'b01) begin n_err++; $display("FAIL addi_dest_sel got %b want 01", out_dest_sel); end
    n_cmp++; if (out_alu_op !== 7'b0001000) begin n_err++; $display("FAIL addi_alu_op got %b want 0001000", out_alu_op); end
    n_cmp++; if (out_alu_src !== 1'b0) begin n_err++; $display("FAIL addi_alu_src got %b want 0", out_alu_src); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drained got %b want 0", out_valid); end
  endtask

  task automatic test_rformat();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'hD8E2; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (out_alu_op !== 7'b1011011) begin n_err++; $display("FAIL rfmt_alu_op got %b want 1011011", out_alu_op); end
    n_cmp++; if (out_alu_src !== 1'b1) begin n_err++; $display("FAIL rfmt_alu_src got %b want 1", out_alu_src); end
    n_cmp++; if (out_dest_sel !== 2'b00) begin n_err++; $display("FAIL rfmt_dest_sel got %b want 00", out_dest_sel); end
    n_cmp++; if (out_reg_write !== 1'b1) begin n_err++; $display("FAIL rfmt_reg_write got %b want 1", out_reg_write); end
    @(negedge clk);
  endtask

  task automatic test_full();
    // A = LD (10001), B = ST (10000), C = branch (01100) which must be refused.
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h8800;
    @(negedge clk); in_instr = 16'h8000;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1 got %b want 1", in_ready); end
    @(negedge clk); in_instr = 16'h6000;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready2 got %b want 0", in_ready); end
    @(negedge clk); out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_with_pop got %b want 0", in_ready); end
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_mem_read, out_mem_to_reg, out_dest_sel, out_mem_write} !== 6'b111010) begin
      n_err++; $display("FAIL full_head_a got %b want 111010", {out_valid, out_mem_read, out_mem_to_reg, out_dest_sel, out_mem_write});
    end
    @(negedge clk);
    n_cmp++; if ({out_valid, out_mem_write, out_rt_rd, out_reg_write, out_branch} !== 5'b11100) begin
      n_err++; $display("FAIL full_head_b got %b want 11100", {out_valid, out_mem_write, out_rt_rd, out_reg_write, out_branch});
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_third_dropped got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] instr [3];
    logic [11:0] exp_f [3];
    // expected {dest_sel, reg_write, jump, link, alu_op[6:0]}
    instr[0] = 16'h3000; exp_f[0] = {2'b11, 1'b1, 1'b1, 1'b1, 7'b0000110};
    instr[1] = 16'h2000; exp_f[1] = {2'b00, 1'b0, 1'b1, 1'b0, 7'b0000100};
    instr[2] = 16'hC000; exp_f[2] = {2'b10, 1'b1, 1'b0, 1'b0, 7'b0011000};
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_instr = instr[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) in_instr = instr[i+1]; else in_valid = 1'b0;
      n_cmp++;
      if ({out_valid, out_dest_sel, out_reg_write, out_jump, out_link, out_alu_op} !== {1'b1, exp_f[i]}) begin
        n_err++; $display("FAIL b2b_%0d got %b want %b", i, {out_valid, out_dest_sel, out_reg_write, out_jump, out_link, out_alu_op}, {1'b1, exp_f[i]});
      end
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b want 0", out_valid); end
  endtask

  task automatic test_halt();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0000;
    @(negedge clk); in_instr = 16'h0800;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL halt_in_ready got %b want 0", in_ready); end
    n_cmp++; if ({out_valid, out_halt, halted} !== 3'b110) begin n_err++; $display("FAIL halt_head got %b want 110", {out_valid, out_halt, halted}); end
    @(negedge clk); out_ready = 1'b1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early got %b want 0", halted); end
    @(negedge clk);
    n_cmp++; if ({halted, out_valid} !== 2'b10) begin n_err++; $display("FAIL halt_halted got %b want 10", {halted, out_valid}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({out_valid, in_ready, halted} !== 3'b001) begin n_err++; $display("FAIL halt_no_accept got %b want 001", {out_valid, in_ready, halted}); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flush_sticky got %b want 1", halted); end
    in_valid = 1'b0;
    #3 rst_n = 1'b0; #1;
    n_cmp++; if ({halted, in_ready} !== 2'b01) begin n_err++; $display("FAIL halt_async_reset got %b want 01", {halted, in_ready}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_halt_flush();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h0000;
    @(negedge clk); in_valid = 1'b0; flush = 1'b1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL hflush_pre got %b want 10", {out_valid, in_ready}); end
    @(negedge clk); flush = 1'b0;
    n_cmp++; if ({out_valid, in_ready, halted} !== 3'b010) begin n_err++; $display("FAIL hflush_post got %b want 010", {out_valid, in_ready, halted}); end
    in_valid = 1'b1; in_instr = 16'h4125; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_reg_write, out_alu_op, halted} !== {1'b1, 1'b1, 7'b0001000, 1'b0}) begin
      n_err++; $display("FAIL hflush_resume got %b want 1100010000", {out_valid, out_reg_write, out_alu_op, halted});
    end
    @(negedge clk);
  endtask

  task automatic test_exc();
    logic exp_exc, exp_rti;
`ifdef DECODE_CTRL_EXC_EN
    exp_exc = 1'b1; exp_rti = 1'b1;
`else
    exp_exc = 1'b0; exp_rti = 1'b0;
`endif
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_instr = 16'h1000;
    @(negedge clk); in_instr = 16'h1800;
    n_cmp++; if ({out_valid, out_exc, out_rti, out_reg_write, out_halt, out_jump, out_alu_op} !== {1'b1, exp_exc, 1'b0, 3'b000, 7'b0000010}) begin
      n_err++; $display("FAIL siic got %b want %b", {out_valid, out_exc, out_rti, out_reg_write, out_halt, out_jump, out_alu_op}, {1'b1, exp_exc, 1'b0, 3'b000, 7'b0000010});
    end
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if ({out_valid, out_exc, out_rti, out_reg_write, out_alu_op} !== {1'b1, 1'b0, exp_rti, 1'b0, 7'b0000011}) begin
      n_err++; $display("FAIL rti got %b want %b", {out_valid, out_exc, out_rti, out_reg_write, out_alu_op}, {1'b1, 1'b0, exp_rti, 1'b0, 7'b0000011});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h8800;
    @(negedge clk); in_instr = 16'h4125;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL rmid_pre got %b want 10", {out_valid, in_ready}); end
    #3 rst_n = 1'b0; #1;
    n_cmp++; if ({out_valid, halted, in_ready, out_mem_read} !== 4'b0010) begin
      n_err++; $display("FAIL rmid_async got %b want 0010", {out_valid, halted, in_ready, out_mem_read});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_lost got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rformat();
    test_full();
    test_back_to_back();
    test_halt();
    test_halt_flush();
    test_exc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
